// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter subsystem (up-counter and
// down_timer). Provides the down_timer state encoding and the default
// counter width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Fixed encoding so the state can be decoded by neighbouring blocks.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } dt_state_e;

endpackage : counter_pkg

// File: rtl/down_timer.sv
// down_timer: loadable programmable down-counter.
//   A start value is accepted through a valid/ready load port. Once started,
//   the counter decrements to zero; the edge that sees zero raises a one-cycle
//   underflow pulse and then either reloads (auto_reload=1) or parks in DONE
//   with a sticky done flag.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   load_valid   load request
//   load_ready   load accepted this cycle (0 only while counting)
//   load_value   start/reload value
//   start        begin/resume counting (level)
//   stop         pause counting (level, wins over start)
//   auto_reload  reload on terminal count instead of stopping
//   count        current counter value
//   busy         counting (state == RUN)
//   underflow    one-cycle pulse after the terminal edge
//   done         sticky terminal flag in one-shot mode
module down_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             underflow,
  output logic             done
);

  dt_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;
  logic             done_q, done_d;

  logic load_fire;
  logic at_zero;
  logic go;

  // load_ready and busy are pure state decodes; everything else is registered.
  assign load_ready = (state_q != ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign load_fire  = load_valid && load_ready;
  assign at_zero    = (count_q == '0);
  assign go         = start && !stop;

  // Next-state logic. A load always wins over start in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_fire) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (load_fire)   state_d = ST_ARMED;
        else if (go)     state_d = ST_RUN;
      end
      ST_RUN: begin
        // stop pauses even at zero, so no terminal event fires while paused.
        if (stop)                          state_d = ST_ARMED;
        else if (at_zero && !auto_reload)  state_d = ST_DONE;
      end
      ST_DONE: begin
        if (load_fire)   state_d = ST_ARMED;
        else if (go)     state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: count, reload value, underflow pulse and done flag.
  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;
    done_d      = done_q;
    if (load_fire) begin
      count_d  = load_value;
      reload_d = load_value;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!stop) begin
            if (!at_zero) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Terminal edge: auto_reload is sampled here, not latched.
              underflow_d = 1'b1;
              if (auto_reload) count_d = reload_q;
              else             done_d  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (go) begin
            count_d = reload_q;
            done_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
      done_q      <= done_d;
    end
  end

  assign count     = count_q;
  assign underflow = underflow_q;
  assign done      = done_q;

endmodule : down_timer
